// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single common data bus into the ROB between the ALU and the
// store/load buffer. Each requester feeds a small result FIFO. A round-robin arbiter
// drains one head entry per cycle into a registered CDB slot. A ROB flush discards
// everything in flight.
// Optional feature: define CDB_BACKPRESSURE_EN to add i_cdb_ready. The slot then holds
// until it is accepted. Without it, the slot reloads or clears every cycle.

module cdb_arbiter #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned PC_W       = 32,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned PTR_W      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_alu_valid,
   input  logic [DATA_W-1:0] i_alu_data,
   input  logic [PC_W-1:0]   i_alu_pc,
   input  logic [PC_W-1:0]   i_alu_jpc,
   output logic              o_alu_ready,
   input  logic              i_slb_valid,
   input  logic [DATA_W-1:0] i_slb_data,
   input  logic [PC_W-1:0]   i_slb_pc,
   output logic              o_slb_ready,
`ifdef CDB_BACKPRESSURE_EN
   input  logic              i_cdb_ready,
`endif
   output logic              o_cdb_valid,
   output logic              o_cdb_src,
   output logic [DATA_W-1:0] o_cdb_data,
   output logic [PC_W-1:0]   o_cdb_pc,
   output logic [PC_W-1:0]   o_cdb_jpc
);

   // rr_last: the requester granted most recently; the other one wins a tie
   typedef enum logic {StGrantAlu, StGrantSlb} rr_state_e;

   localparam logic [PTR_W:0] L_FULL = FIFO_DEPTH[PTR_W:0];

   rr_state_e r_rr_last, w_rr_next;

   logic [DATA_W-1:0] r_alu_data [FIFO_DEPTH];
   logic [PC_W-1:0]   r_alu_pc   [FIFO_DEPTH];
   logic [PC_W-1:0]   r_alu_jpc  [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_alu_wr_ptr, r_alu_rd_ptr;
   logic [PTR_W:0]    r_alu_cnt, w_alu_cnt_next;

   logic [DATA_W-1:0] r_slb_data [FIFO_DEPTH];
   logic [PC_W-1:0]   r_slb_pc   [FIFO_DEPTH];
   logic [PC_W-1:0]   r_slb_jpc  [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_slb_wr_ptr, r_slb_rd_ptr;
   logic [PTR_W:0]    r_slb_cnt, w_slb_cnt_next;

   logic              r_cdb_valid;
   logic              r_cdb_src;
   logic [DATA_W-1:0] r_cdb_data;
   logic [PC_W-1:0]   r_cdb_pc;
   logic [PC_W-1:0]   r_cdb_jpc;

   logic w_cdb_ready;
   logic w_load_ok;
   logic w_alu_ne, w_slb_ne;
   logic w_grant_alu, w_grant_slb;
   logic w_alu_push, w_slb_push;
   logic w_alu_pop, w_slb_pop;

`ifdef CDB_BACKPRESSURE_EN
   assign w_cdb_ready = i_cdb_ready;
`else
   assign w_cdb_ready = 1'b1;
`endif

   // Ready depends on the count only, so a full FIFO refuses a push even while popping
   assign o_alu_ready = (r_alu_cnt != L_FULL);
   assign o_slb_ready = (r_slb_cnt != L_FULL);

   assign w_load_ok = ~r_cdb_valid | w_cdb_ready;
   assign w_alu_ne  = (r_alu_cnt != '0);
   assign w_slb_ne  = (r_slb_cnt != '0);

   assign w_grant_alu = w_load_ok & w_alu_ne & (~w_slb_ne | (r_rr_last == StGrantSlb));
   assign w_grant_slb = w_load_ok & w_slb_ne & (~w_alu_ne | (r_rr_last == StGrantAlu));

   // Flush wins over everything: no entry is written or consumed in that cycle
   assign w_alu_push = i_alu_valid & o_alu_ready & ~i_flush;
   assign w_slb_push = i_slb_valid & o_slb_ready & ~i_flush;
   assign w_alu_pop  = w_grant_alu & ~i_flush;
   assign w_slb_pop  = w_grant_slb & ~i_flush;

   // FIFO occupancy next-state from push/pop
   always_comb begin
      w_alu_cnt_next = r_alu_cnt;
      w_slb_cnt_next = r_slb_cnt;
      case ({w_alu_push, w_alu_pop})
         2'b10:   w_alu_cnt_next = r_alu_cnt + 1'b1;
         2'b01:   w_alu_cnt_next = r_alu_cnt - 1'b1;
         default: w_alu_cnt_next = r_alu_cnt;
      endcase
      case ({w_slb_push, w_slb_pop})
         2'b10:   w_slb_cnt_next = r_slb_cnt + 1'b1;
         2'b01:   w_slb_cnt_next = r_slb_cnt - 1'b1;
         default: w_slb_cnt_next = r_slb_cnt;
      endcase
   end

   // FIFO pointers and counts; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_wr_ptr <= '0;
         r_alu_rd_ptr <= '0;
         r_alu_cnt    <= '0;
         r_slb_wr_ptr <= '0;
         r_slb_rd_ptr <= '0;
         r_slb_cnt    <= '0;
      end else if (i_flush) begin
         r_alu_wr_ptr <= '0;
         r_alu_rd_ptr <= '0;
         r_alu_cnt    <= '0;
         r_slb_wr_ptr <= '0;
         r_slb_rd_ptr <= '0;
         r_slb_cnt    <= '0;
      end else begin
         if (w_alu_push) r_alu_wr_ptr <= r_alu_wr_ptr + 1'b1;
         if (w_alu_pop)  r_alu_rd_ptr <= r_alu_rd_ptr + 1'b1;
         if (w_slb_push) r_slb_wr_ptr <= r_slb_wr_ptr + 1'b1;
         if (w_slb_pop)  r_slb_rd_ptr <= r_slb_rd_ptr + 1'b1;
         r_alu_cnt <= w_alu_cnt_next;
         r_slb_cnt <= w_slb_cnt_next;
      end
   end

   // FIFO storage; contents are don't-care while the count says empty
   always_ff @(posedge clk) begin
      if (w_alu_push) begin
         r_alu_data[r_alu_wr_ptr] <= i_alu_data;
         r_alu_pc[r_alu_wr_ptr]   <= i_alu_pc;
         r_alu_jpc[r_alu_wr_ptr]  <= i_alu_jpc;
      end
      if (w_slb_push) begin
         r_slb_data[r_slb_wr_ptr] <= i_slb_data;
         r_slb_pc[r_slb_wr_ptr]   <= i_slb_pc;
         r_slb_jpc[r_slb_wr_ptr]  <= i_slb_pc + PC_W'(4);
      end
   end

   // Round-robin state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_last <= StGrantSlb;
      end else begin
         r_rr_last <= w_rr_next;
      end
   end

   // Round-robin next state: follows the winner, reset to SLB on flush
   always_comb begin
      w_rr_next = r_rr_last;
      if (i_flush) begin
         w_rr_next = StGrantSlb;
      end else if (w_grant_alu) begin
         w_rr_next = StGrantAlu;
      end else if (w_grant_slb) begin
         w_rr_next = StGrantSlb;
      end
   end

   // CDB slot: load the winner's head, clear when nothing wins, hold while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cdb_valid <= 1'b0;
         r_cdb_src   <= 1'b0;
         r_cdb_data  <= '0;
         r_cdb_pc    <= '0;
         r_cdb_jpc   <= '0;
      end else if (i_flush) begin
         r_cdb_valid <= 1'b0;
      end else if (w_load_ok) begin
         if (w_grant_alu) begin
            r_cdb_valid <= 1'b1;
            r_cdb_src   <= 1'b0;
            r_cdb_data  <= r_alu_data[r_alu_rd_ptr];
            r_cdb_pc    <= r_alu_pc[r_alu_rd_ptr];
            r_cdb_jpc   <= r_alu_jpc[r_alu_rd_ptr];
         end else if (w_grant_slb) begin
            r_cdb_valid <= 1'b1;
            r_cdb_src   <= 1'b1;
            r_cdb_data  <= r_slb_data[r_slb_rd_ptr];
            r_cdb_pc    <= r_slb_pc[r_slb_rd_ptr];
            r_cdb_jpc   <= r_slb_jpc[r_slb_rd_ptr];
         end else begin
            r_cdb_valid <= 1'b0;
         end
      end
   end

   assign o_cdb_valid = r_cdb_valid;
   assign o_cdb_src   = r_cdb_src;
   assign o_cdb_data  = r_cdb_data;
   assign o_cdb_pc    = r_cdb_pc;
   assign o_cdb_jpc   = r_cdb_jpc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed stimulus for cdb_arbiter, checked against a
// queue-based reference model of the two FIFOs, the round-robin choice and the CDB slot.

module tb_cdb_arbiter;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
      logic [31:0] jpc;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        alu_valid;
   logic [31:0] alu_data, alu_pc, alu_jpc;
   logic        alu_ready;
   logic        slb_valid;
   logic [31:0] slb_data, slb_pc;
   logic        slb_ready;
`ifdef CDB_BACKPRESSURE_EN
   logic        cdb_ready;
`endif
   logic        cdb_valid, cdb_src;
   logic [31:0] cdb_data, cdb_pc, cdb_jpc;

   always #5 clk = ~clk;

   cdb_arbiter #(
      .DATA_W    (32),
      .PC_W      (32),
      .FIFO_DEPTH(DEPTH),
      .PTR_W     (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (flush),
      .i_alu_valid(alu_valid),
      .i_alu_data (alu_data),
      .i_alu_pc   (alu_pc),
      .i_alu_jpc  (alu_jpc),
      .o_alu_ready(alu_ready),
      .i_slb_valid(slb_valid),
      .i_slb_data (slb_data),
      .i_slb_pc   (slb_pc),
      .o_slb_ready(slb_ready),
`ifdef CDB_BACKPRESSURE_EN
      .i_cdb_ready(cdb_ready),
`endif
      .o_cdb_valid(cdb_valid),
      .o_cdb_src  (cdb_src),
      .o_cdb_data (cdb_data),
      .o_cdb_pc   (cdb_pc),
      .o_cdb_jpc  (cdb_jpc)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   ent_t alu_q[$];
   ent_t slb_q[$];
   ent_t m_slot;
   logic m_v;
   logic m_src;
   logic m_rr_slb;

   int   acc_cnt;
   int   obs_cnt;
   logic t3_on = 1'b0;
   logic exp_src;
   int   t3_seen;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      alu_q.delete();
      slb_q.delete();
      m_slot   = '0;
      m_v      = 1'b0;
      m_src    = 1'b0;
      m_rr_slb = 1'b1;
   endtask

   task automatic check_outputs();
      check_eq("alu_ready", 32'(alu_ready), 32'(alu_q.size() != DEPTH));
      check_eq("slb_ready", 32'(slb_ready), 32'(slb_q.size() != DEPTH));
      check_eq("cdb_valid", 32'(cdb_valid), 32'(m_v));
      if (m_v) begin
         check_eq("cdb_src", 32'(cdb_src), 32'(m_src));
         check_eq("cdb_data", cdb_data, m_slot.data);
         check_eq("cdb_pc", cdb_pc, m_slot.pc);
         check_eq("cdb_jpc", cdb_jpc, m_slot.jpc);
      end
      if (cdb_valid === 1'b1) obs_cnt++;
      if (t3_on && cdb_valid === 1'b1 && t3_seen < 8) begin
         check_eq("t3_alternate", 32'(cdb_src), 32'(exp_src));
         exp_src = ~exp_src;
         t3_seen++;
      end
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model, check after the edge
   task automatic cycle(input logic av, input logic [31:0] ad, input logic [31:0] ap,
                        input logic [31:0] aj, input logic sv, input logic [31:0] sd,
                        input logic [31:0] sp, input logic fl, input logic cr);
      logic eff_cr, a_rdy, s_rdy, ca, cs;
      alu_valid = av;
      alu_data  = ad;
      alu_pc    = ap;
      alu_jpc   = aj;
      slb_valid = sv;
      slb_data  = sd;
      slb_pc    = sp;
      flush     = fl;
`ifdef CDB_BACKPRESSURE_EN
      cdb_ready = cr;
      eff_cr    = cr;
`else
      // No backpressure port: the ROB always takes the slot
      eff_cr    = 1'b1 | cr;
`endif
      a_rdy = (alu_q.size() != DEPTH);
      s_rdy = (slb_q.size() != DEPTH);
      if (fl) begin
         model_reset();
      end else begin
         if (!m_v || eff_cr) begin
            ca = (alu_q.size() > 0);
            cs = (slb_q.size() > 0);
            if (ca && (!cs || m_rr_slb)) begin
               m_slot   = alu_q.pop_front();
               m_v      = 1'b1;
               m_src    = 1'b0;
               m_rr_slb = 1'b0;
            end else if (cs) begin
               m_slot   = slb_q.pop_front();
               m_v      = 1'b1;
               m_src    = 1'b1;
               m_rr_slb = 1'b1;
            end else begin
               m_v = 1'b0;
            end
         end
         if (av && a_rdy) begin
            alu_q.push_back('{data: ad, pc: ap, jpc: aj});
            acc_cnt++;
         end
         if (sv && s_rdy) begin
            slb_q.push_back('{data: sd, pc: sp, jpc: sp + 32'd4});
            acc_cnt++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle();
      cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic do_flush();
      cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
   endtask

   initial begin
      logic [31:0] held_pc;
      rst       = 1'b1;
      flush     = 1'b0;
      alu_valid = 1'b0;
      alu_data  = '0;
      alu_pc    = '0;
      alu_jpc   = '0;
      slb_valid = 1'b0;
      slb_data  = '0;
      slb_pc    = '0;
`ifdef CDB_BACKPRESSURE_EN
      cdb_ready = 1'b1;
`endif
      acc_cnt = 0;
      obs_cnt = 0;
      model_reset();
      repeat (2) @(negedge clk);

      // Reset state
      check_eq("rst_valid", 32'(cdb_valid), 32'd0);
      check_eq("rst_src", 32'(cdb_src), 32'd0);
      check_eq("rst_data", cdb_data, 32'd0);
      check_eq("rst_pc", cdb_pc, 32'd0);
      check_eq("rst_jpc", cdb_jpc, 32'd0);
      check_eq("rst_alu_ready", 32'(alu_ready), 32'd1);
      check_eq("rst_slb_ready", 32'(slb_ready), 32'd1);
      rst = 1'b0;

      // Single ALU result: no bypass, then exactly one valid cycle
      cycle(1'b1, 32'd5, 32'h10, 32'h14, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      check_eq("t1_not_yet", 32'(cdb_valid), 32'd0);
      idle();
      check_eq("t1_valid", 32'(cdb_valid), 32'd1);
      check_eq("t1_src", 32'(cdb_src), 32'd0);
      check_eq("t1_data", cdb_data, 32'd5);
      check_eq("t1_pc", cdb_pc, 32'h10);
      check_eq("t1_jpc", cdb_jpc, 32'h14);
      idle();
      check_eq("t1_pulse_end", 32'(cdb_valid), 32'd0);

      // SLB jpc wraps mod 2^32
      cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 32'hAB, 32'hFFFF_FFFC, 1'b0, 1'b1);
      idle();
      check_eq("t2_valid", 32'(cdb_valid), 32'd1);
      check_eq("t2_src", 32'(cdb_src), 32'd1);
      check_eq("t2_data", cdb_data, 32'hAB);
      check_eq("t2_jpc", cdb_jpc, 32'h0);
      idle();

      // Sustained two-sided load: strict alternation, nothing lost or duplicated
      do_flush();
      acc_cnt = 0;
      obs_cnt = 0;
      t3_on   = 1'b1;
      exp_src = 1'b0;
      t3_seen = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 32'h100 + 32'(i), 32'h1000 + 32'(4 * i), 32'h2000 + 32'(i), 1'b1,
               32'h200 + 32'(i), 32'h3000 + 32'(4 * i), 1'b0, 1'b1);
      end
      repeat (6) idle();
      t3_on = 1'b0;
      check_eq("t3_outputs_seen", 32'(t3_seen), 32'd8);
      check_eq("t3_no_loss", 32'(obs_cnt), 32'(acc_cnt));

`ifdef CDB_BACKPRESSURE_EN
      // Stall for 5 cycles with both sides loaded, then release
      do_flush();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 32'h400 + 32'(i), 32'h4000 + 32'(4 * i), 32'h4800 + 32'(i), 1'b1,
               32'h500 + 32'(i), 32'h5000 + 32'(4 * i), 1'b0, 1'b0);
         if (i == 1) held_pc = cdb_pc;
      end
      check_eq("t4_held_valid", 32'(cdb_valid), 32'd1);
      check_eq("t4_held_pc", cdb_pc, held_pc);
      check_eq("t4_alu_full", 32'(alu_ready), 32'd0);
      check_eq("t4_slb_full", 32'(slb_ready), 32'd0);
      repeat (6) idle();
`endif

      // Flush alongside an ALU push with two SLB results queued
      do_flush();
      cycle(1'b1, 32'h600, 32'h6000, 32'h6004, 1'b1, 32'h700, 32'h7000, 1'b0, 1'b1);
      cycle(1'b1, 32'h601, 32'h6010, 32'h6014, 1'b1, 32'h701, 32'h7010, 1'b0, 1'b1);
      check_eq("t5_slb_two_queued", 32'(slb_ready), 32'd0);
      cycle(1'b1, 32'h602, 32'h6020, 32'h6024, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
      check_eq("t5_valid_clear", 32'(cdb_valid), 32'd0);
      check_eq("t5_alu_ready", 32'(alu_ready), 32'd1);
      check_eq("t5_slb_ready", 32'(slb_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         idle();
         check_eq("t5_nothing_after", 32'(cdb_valid), 32'd0);
      end

      // Randomized traffic with occasional flushes and stalls
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 99) < 60, $urandom, $urandom, $urandom,
               $urandom_range(0, 99) < 55, $urandom, $urandom,
               $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
      end

      // Asynchronous reset while the slot is valid
      for (int i = 0; i < 50 && !m_v; i++) begin
         cycle(1'b1, $urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, 1'b0, 1'b1);
      end
      check_eq("t6_pre_valid", 32'(cdb_valid), 32'd1);
      alu_valid = 1'b0;
      slb_valid = 1'b0;
      flush     = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_eq("t6_async_valid", 32'(cdb_valid), 32'd0);
      check_eq("t6_async_alu_ready", 32'(alu_ready), 32'd1);
      check_eq("t6_async_slb_ready", 32'(slb_ready), 32'd1);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 32'h900, 32'h9000, 32'h9004, 1'b1, 32'hA00, 32'hA000, 1'b0, 1'b1);
      idle();
      check_eq("t6_tie_alu_first", 32'(cdb_src), 32'd0);
      check_eq("t6_tie_valid", 32'(cdb_valid), 32'd1);
      idle();
      check_eq("t6_then_slb", 32'(cdb_src), 32'd1);
      repeat (3) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
